muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit implementing the RV32M/RV64M operation set for the EX stage of the pipelined core. It accepts one operation from ID/EX, computes it over a fixed number of cycles with a radix-2 shift-add/shift-subtract engine, and asserts a stall to the hazard logic while busy. It returns the result with its destination register tag for EX/MEM. It supports pipeline flush (branch mispredict) mid-operation.

---
 rtl/muldiv_unit_if.sv | 30 +++
 rtl/muldiv_unit.sv | 195 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the ID/EX stage and the
// iterative multiply/divide unit. The master side issues operations and
// flushes; the slave side (the unit) reports busy/stall and returns results.
`timescale 1ns/1ps
interface muldiv_unit_if #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic [TAGW-1:0] rd_i;
  logic            flush_i;
  logic            busy_o;
  logic            stall_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;
  logic [TAGW-1:0] rd_o;

  modport master (
    output start_i, op_i, a_i, b_i, rd_i, flush_i,
    input  busy_o, stall_o, valid_o, result_o, rd_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, rd_i, flush_i,
    output busy_o, stall_o, valid_o, result_o, rd_o
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 RV32M/RV64M multiply/divide unit for the EX
// stage. Operands are converted to magnitudes on accept, XLEN shift-add or
// restoring shift-subtract iterations run in CALC, and FIX applies the sign
// correction and the divide-by-zero quotient before the one-cycle valid strobe.
// Configuration macro MULDIV_DIV_EN: when defined the divide datapath is built;
// when undefined, divide/remainder ops keep the same handshake and latency but
// return zero.
`timescale 1ns/1ps
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic            accept;
  logic            last_iter;
  logic            a_signed, b_signed;
  logic            neg_a_in, neg_b_in;
  logic [XLEN-1:0] a_mag, b_mag;

  logic [CW-1:0]   count_q;
  logic [2:0]      op_q;
  logic            neg_a_q, neg_b_q;
  logic [TAGW-1:0] rd_q;
  logic [TAGW-1:0] rd_out_q;
  logic [XLEN-1:0] opnd_q;
  logic [XLEN-1:0] result_q;

  // acc_q holds the 2*XLEN product (plus carry) while multiplying, or the
  // XLEN+1 bit partial remainder above the shifting dividend/quotient while
  // dividing; opnd_q is the multiplicand or the divisor respectively.
  logic [2*XLEN:0]   acc_q;
  logic [2*XLEN:0]   step_next;
  logic [2*XLEN:0]   mul_next;
  logic [XLEN:0]     add_sum;
  logic [2*XLEN-1:0] prod_mag, prod_fix;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN-1:0]   fix_result;

`ifdef MULDIV_DIV_EN
  logic            b_zero_q;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] diff;
  logic [2*XLEN:0] div_next;
  logic [XLEN-1:0] quot, rem, div_res;
`endif

  assign accept    = bus.start_i && !bus.flush_i &&
                     (state_q == S_IDLE || state_q == S_DONE);
  assign last_iter = (count_q == CW'(XLEN - 1));

  assign bus.busy_o   = (state_q == S_CALC) || (state_q == S_FIX);
  assign bus.stall_o  = bus.busy_o ||
                        (bus.start_i && (state_q == S_IDLE || state_q == S_DONE));
  assign bus.valid_o  = (state_q == S_DONE);
  assign bus.result_o = result_q;
  assign bus.rd_o     = rd_out_q;

  // Decode operand signedness from funct3 and form operand magnitudes.
  always_comb begin
    a_signed = (bus.op_i == 3'b001) || (bus.op_i == 3'b010) ||
               (bus.op_i == 3'b100) || (bus.op_i == 3'b110);
    b_signed = (bus.op_i == 3'b001) || (bus.op_i == 3'b100) ||
               (bus.op_i == 3'b110);
    neg_a_in = a_signed && bus.a_i[XLEN-1];
    neg_b_in = b_signed && bus.b_i[XLEN-1];
    a_mag    = neg_a_in ? -bus.a_i : bus.a_i;
    b_mag    = neg_b_in ? -bus.b_i : bus.b_i;
  end

  // One radix-2 iteration: conditional add then shift right for multiply,
  // trial subtract then shift left for divide.
  always_comb begin
    add_sum  = acc_q[2*XLEN:XLEN] + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {1'b0, add_sum, acc_q[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    shifted  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff     = {1'b0, shifted} - {2'b00, opnd_q};
    div_next = diff[XLEN+1] ? {shifted, acc_q[XLEN-2:0], 1'b0}
                            : {diff[XLEN:0], acc_q[XLEN-2:0], 1'b1};
    step_next = op_q[2] ? div_next : mul_next;
`else
    step_next = mul_next;
`endif
  end

  // Sign correction and result selection applied during FIX.
  always_comb begin
    prod_mag = acc_q[2*XLEN-1:0];
    prod_fix = (neg_a_q ^ neg_b_q) ? -prod_mag : prod_mag;
    mul_res  = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
    quot    = acc_q[XLEN-1:0];
    rem     = acc_q[2*XLEN-1:XLEN];
    if (op_q[1]) begin
      div_res = neg_a_q ? -rem : rem;
    end else if (b_zero_q) begin
      div_res = '1;
    end else begin
      div_res = (neg_a_q ^ neg_b_q) ? -quot : quot;
    end
    fix_result = op_q[2] ? div_res : mul_res;
`else
    fix_result = op_q[2] ? '0 : mul_res;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush always wins over a new request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_CALC;
      end
      S_CALC: begin
        if (bus.flush_i) begin
          state_d = S_IDLE;
        end else if (last_iter) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = bus.flush_i ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        state_d = accept ? S_CALC : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operand capture on accept, iteration in CALC, result latch at the end of FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      rd_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
`ifdef MULDIV_DIV_EN
      b_zero_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        count_q <= '0;
        op_q    <= bus.op_i;
        neg_a_q <= neg_a_in;
        neg_b_q <= neg_b_in;
        rd_q    <= bus.rd_i;
        opnd_q  <= bus.op_i[2] ? b_mag : a_mag;
        acc_q   <= {{(XLEN + 1){1'b0}}, (bus.op_i[2] ? a_mag : b_mag)};
`ifdef MULDIV_DIV_EN
        b_zero_q <= (bus.b_i == '0);
`endif
      end else if (state_q == S_CALC) begin
        acc_q   <= step_next;
        count_q <= count_q + CW'(1);
      end
      if (state_q == S_FIX && !bus.flush_i) begin
        result_q <= fix_result;
        rd_out_q <= rd_q;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (XLEN=32). Expected
// results come from a behavioural RV32M model and are queued when a request
// is driven, then popped when valid_o appears. Divide expectations follow
// MULDIV_DIV_EN so the bench matches either build.
`timescale 1ns/1ps
module tb_muldiv_unit;
  localparam int XLEN = 32;
  localparam int TAGW = 5;
  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010,
                         OP_MULHU = 3'b011, OP_DIV = 3'b100, OP_DIVU = 3'b101,
                         OP_REM = 3'b110, OP_REMU = 3'b111;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int passes = 0;
  exp_t exp_q[$];
  logic [31:0] last_result = '0;
  logic [4:0]  last_rd = '0;

  muldiv_unit_if #(.XLEN(XLEN), .TAGW(TAGW)) bus ();

  muldiv_unit #(.XLEN(XLEN), .TAGW(TAGW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p  = '0;
    case (op)
      OP_MUL:    begin p = sa * sb; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        return op[1] ? 32'(ua % ub) : 32'(ua / ub);
`else
        return 32'd0;
`endif
      end
    endcase
  endfunction

  // Drive one request for a single accepting edge and queue its expected result.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd);
    exp_t e;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i = op;
    bus.a_i = a;
    bus.b_i = b;
    bus.rd_i = rd;
    e.result = model(op, a, b);
    e.rd = rd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  // Wait (bounded) for valid_o after an accepting edge; reports cycle count
  // from the request cycle and whether busy/stall stayed high meanwhile.
  task automatic wait_valid(output int cycles, output bit busy_ok);
    cycles = 1;
    busy_ok = 1'b1;
    while (bus.valid_o !== 1'b1 && cycles <= 60) begin
      if (bus.busy_o !== 1'b1 || bus.stall_o !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    bus.start_i = 1'b0; bus.op_i = '0; bus.a_i = '0; bus.b_i = '0;
    bus.rd_i = '0; bus.flush_i = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy_o !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", bus.busy_o); else passes++;
    checks++; if (bus.valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", bus.valid_o); else passes++;
    checks++; if (bus.stall_o !== 1'b0) $display("[TB] FAIL reset_stall: got %b want 0", bus.stall_o); else passes++;
    checks++; if (bus.result_o !== 32'd0) $display("[TB] FAIL reset_result: got %h want 0", bus.result_o); else passes++;
    checks++; if (bus.rd_o !== 5'd0) $display("[TB] FAIL reset_rd: got %0d want 0", bus.rd_o); else passes++;
    bus.start_i = 1'b1;
    #1;
    checks++; if (bus.stall_o !== 1'b1) $display("[TB] FAIL idle_start_stall: got %b want 1", bus.stall_o); else passes++;
    @(negedge clk);
    bus.start_i = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_mul_basic();
    int cyc;
    bit ok;
    exp_t e;
    applyStimulus(OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd9);
    wait_valid(cyc, ok);
    e = exp_q.pop_front();
    checks++; if (cyc != 34) $display("[TB] FAIL mul_latency: got %0d want 34", cyc); else passes++;
    checks++; if (bus.result_o !== 32'hFFFF_FFEB) $display("[TB] FAIL mul_result: got %h want ffffffeb", bus.result_o); else passes++;
    checks++; if (bus.rd_o !== 5'd9) $display("[TB] FAIL mul_rd: got %0d want 9", bus.rd_o); else passes++;
    checks++; if (ok !== 1'b1) $display("[TB] FAIL mul_busy_stall: got %b want 1", ok); else passes++;
    last_result = e.result;
    last_rd = e.rd;
    @(posedge clk);
    #1;
    checks++; if (bus.valid_o !== 1'b0) $display("[TB] FAIL valid_one_cycle: got %b want 0", bus.valid_o); else passes++;
    checks++; if (bus.result_o !== last_result) $display("[TB] FAIL result_hold: got %h want %h", bus.result_o, last_result); else passes++;
  endtask

  task automatic test_mul_high();
    logic [2:0]  ops [3];
    logic [31:0] as [3];
    logic [31:0] bs [3];
    int cyc;
    bit ok;
    exp_t e;
    ops = '{OP_MULH, OP_MULHU, OP_MULHSU};
    as  = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    bs  = '{32'h8000_0000, 32'h8000_0000, 32'd2};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(ops[i], as[i], bs[i], 5'(i + 1));
      wait_valid(cyc, ok);
      e = exp_q.pop_front();
      checks++; if (bus.result_o !== e.result) $display("[TB] FAIL mulh_result[%0d]: got %h want %h", i, bus.result_o, e.result); else passes++;
      checks++; if (bus.rd_o !== e.rd) $display("[TB] FAIL mulh_rd[%0d]: got %0d want %0d", i, bus.rd_o, e.rd); else passes++;
      last_result = e.result;
      last_rd = e.rd;
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [8];
    logic [31:0] as [8];
    logic [31:0] bs [8];
    int cyc;
    bit ok;
    exp_t e;
    ops = '{OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
    as  = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
            32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    bs  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(ops[i], as[i], bs[i], 5'(i + 10));
      wait_valid(cyc, ok);
      e = exp_q.pop_front();
      checks++; if (cyc != 34) $display("[TB] FAIL div_latency[%0d]: got %0d want 34", i, cyc); else passes++;
      checks++; if (bus.result_o !== e.result) $display("[TB] FAIL div_result[%0d]: got %h want %h", i, bus.result_o, e.result); else passes++;
      last_result = e.result;
      last_rd = e.rd;
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    int cyc;
    bit ok;
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 40)) : $urandom;
      applyStimulus(op, a, b, 5'($urandom_range(0, 31)));
      wait_valid(cyc, ok);
      e = exp_q.pop_front();
      checks++; if (bus.result_o !== e.result) $display("[TB] FAIL rand_result[%0d] op %0d a %h b %h: got %h want %h", i, op, a, b, bus.result_o, e.result); else passes++;
      checks++; if (bus.rd_o !== e.rd) $display("[TB] FAIL rand_rd[%0d]: got %0d want %0d", i, bus.rd_o, e.rd); else passes++;
      last_result = e.result;
      last_rd = e.rd;
    end
  endtask

  task automatic test_flush();
    int cyc;
    bit ok;
    bit seen;
    exp_t e;
    applyStimulus(OP_MUL, 32'd12345, 32'd678, 5'd3);
    e = exp_q.pop_back();
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    checks++; if (bus.busy_o !== 1'b0) $display("[TB] FAIL flush_busy: got %b want 0", bus.busy_o); else passes++;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.valid_o !== 1'b0) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++; if (seen !== 1'b0) $display("[TB] FAIL flush_no_valid: got %b want 0", seen); else passes++;
    checks++; if (bus.result_o !== last_result) $display("[TB] FAIL flush_result_kept: got %h want %h", bus.result_o, last_result); else passes++;
    checks++; if (bus.rd_o !== last_rd) $display("[TB] FAIL flush_rd_kept: got %0d want %0d", bus.rd_o, last_rd); else passes++;
    applyStimulus(OP_DIVU, 32'd9, 32'd4, 5'd7);
    wait_valid(cyc, ok);
    e = exp_q.pop_front();
    checks++; if (cyc != 34) $display("[TB] FAIL after_flush_latency: got %0d want 34", cyc); else passes++;
    checks++; if (bus.result_o !== e.result) $display("[TB] FAIL after_flush_result: got %h want %h", bus.result_o, e.result); else passes++;
    last_result = e.result;
    last_rd = e.rd;
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit ok;
    exp_t e;
    applyStimulus(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 5'd1);
    wait_valid(cyc, ok);
    e = exp_q.pop_front();
    checks++; if (bus.result_o !== e.result) $display("[TB] FAIL b2b_first_result: got %h want %h", bus.result_o, e.result); else passes++;
    bus.start_i = 1'b1;
    bus.op_i = OP_MUL;
    bus.a_i = 32'hFFFF_FFFF;
    bus.b_i = 32'd5;
    bus.rd_i = 5'd2;
    e.result = model(OP_MUL, 32'hFFFF_FFFF, 32'd5);
    e.rd = 5'd2;
    exp_q.push_back(e);
    #1;
    checks++; if (bus.stall_o !== 1'b1) $display("[TB] FAIL done_start_stall: got %b want 1", bus.stall_o); else passes++;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    checks++; if (bus.busy_o !== 1'b1) $display("[TB] FAIL b2b_no_gap: got %b want 1", bus.busy_o); else passes++;
    wait_valid(cyc, ok);
    e = exp_q.pop_front();
    checks++; if (cyc != 34) $display("[TB] FAIL b2b_latency: got %0d want 34", cyc); else passes++;
    checks++; if (bus.result_o !== e.result) $display("[TB] FAIL b2b_second_result: got %h want %h", bus.result_o, e.result); else passes++;
    checks++; if (bus.rd_o !== e.rd) $display("[TB] FAIL b2b_second_rd: got %0d want %0d", bus.rd_o, e.rd); else passes++;
    last_result = e.result;
    last_rd = e.rd;
    // Flush while DONE with a new request: valid stays this cycle, request dropped.
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    bus.op_i = OP_MUL;
    #1;
    checks++; if (bus.valid_o !== 1'b1) $display("[TB] FAIL done_flush_valid: got %b want 1", bus.valid_o); else passes++;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    checks++; if (bus.busy_o !== 1'b0) $display("[TB] FAIL done_flush_busy: got %b want 0", bus.busy_o); else passes++;
    checks++; if (bus.valid_o !== 1'b0) $display("[TB] FAIL done_flush_valid_drop: got %b want 0", bus.valid_o); else passes++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    exp_t e;
    applyStimulus(OP_DIV, 32'd1000, 32'd7, 5'd12);
    e = exp_q.pop_back();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.busy_o !== 1'b0) $display("[TB] FAIL midreset_busy: got %b want 0", bus.busy_o); else passes++;
    checks++; if (bus.stall_o !== 1'b0) $display("[TB] FAIL midreset_stall: got %b want 0", bus.stall_o); else passes++;
    checks++; if (bus.result_o !== 32'd0) $display("[TB] FAIL midreset_result: got %h want 0", bus.result_o); else passes++;
    checks++; if (bus.rd_o !== 5'd0) $display("[TB] FAIL midreset_rd: got %0d want 0", bus.rd_o); else passes++;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.valid_o !== 1'b0) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++; if (seen !== 1'b0) $display("[TB] FAIL midreset_no_valid: got %b want 0", seen); else passes++;
  endtask

  initial begin
    $display("[TB] starting muldiv_unit bench");
    test_reset();
    test_mul_basic();
    test_mul_high();
    test_div();
    test_random();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
